// File: rtl/tm1640_serial_writer_pkg.sv
// Purpose: shared types and constants for the TM1640 two-wire serial writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tm1640_serial_writer_pkg;

    // Line-sequencing states; one protocol tick is spent in each non-IDLE state.
    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH,
        STOP_END
    } state_t;

    // A pos of this value turns the request into a single command byte.
    localparam logic [7:0] CMD_ONLY_POS = 8'hFF;

    // Display constants used by the sequencer that drives this block.
    localparam logic [7:0] DISP_ON_CMD = 8'h89;
    localparam logic [7:0] ADDR_BASE   = 8'hC0;

endpackage

// File: rtl/tm1640_serial_writer_tick_divider.sv
// Purpose: protocol tick generator; counts system clocks while enabled.
// Latency: tick pulses for one clock every TICK_CYCLES clocks after enable rises.
// Backpressure: none; counter is held at 0 while en=0.
//
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-high reset
//   en   - count enable; counter cleared while low
//   tick - one-cycle pulse on the last clock of each tick period
module tm1640_serial_writer_tick_divider
    import tm1640_serial_writer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/tm1640_serial_writer.sv
// Purpose: TM1640 two-wire write engine; sends one command byte or an address+data pair.
// Latency: busy for (4 + 16*nbytes) * TICK_CYCLES clocks from the accepting edge.
// Backpressure: valid is only sampled while busy=0; requests during busy are dropped.
//
// Ports:
//   CLK, RST      - system clock, asynchronous active-high reset
//   valid         - request strobe
//   pos           - address byte, or CMD_ONLY_POS for a command-only transfer
//   value         - command byte or segment data byte
//   o_sclk, o_din - registered serial clock / data lines to the display
//   busy          - registered transfer-in-progress flag
module tm1640_serial_writer #(
    parameter int unsigned TICK_CYCLES  = 15,
    parameter logic [7:0]  CMD_ONLY_POS = tm1640_serial_writer_pkg::CMD_ONLY_POS
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       valid,
    input  logic [7:0] pos,
    input  logic [7:0] value,
    output logic       o_sclk,
    output logic       o_din,
    output logic       busy
);

    import tm1640_serial_writer_pkg::*;

    state_t     state, state_nxt;
    logic       tick;
    logic [7:0] byte0, byte1;
    logic       two_bytes;
    logic [2:0] bit_cnt, bit_nxt;
    logic       byte_cnt, byte_nxt;
    logic [7:0] cur_byte;
    logic       sclk_nxt, din_nxt, busy_nxt;

    tm1640_serial_writer_tick_divider #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .en   (state != IDLE),
        .tick (tick)
    );

    // State and bit/byte position registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
        end
    end

    // Request capture: byte0 is always the first byte on the wire.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            byte0     <= '0;
            byte1     <= '0;
            two_bytes <= 1'b0;
        end else if ((state == IDLE) && valid) begin
            byte0     <= (pos == CMD_ONLY_POS) ? value : pos;
            byte1     <= value;
            two_bytes <= (pos != CMD_ONLY_POS);
        end
    end

    // Next-state logic; everything but the IDLE accept waits for a tick.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        byte_nxt  = byte_cnt;
        case (state)
            IDLE: begin
                bit_nxt  = '0;
                byte_nxt = 1'b0;
                if (valid) state_nxt = START;
            end
            START:     if (tick) state_nxt = BIT_LOW;
            BIT_LOW:   if (tick) state_nxt = BIT_HIGH;
            BIT_HIGH: begin
                if (tick) begin
                    if (bit_cnt != 3'd7) begin
                        bit_nxt   = bit_cnt + 3'd1;
                        state_nxt = BIT_LOW;
                    end else if (two_bytes && !byte_cnt) begin
                        // Second byte follows directly, no gap tick.
                        bit_nxt   = '0;
                        byte_nxt  = 1'b1;
                        state_nxt = BIT_LOW;
                    end else begin
                        state_nxt = STOP_LOW;
                    end
                end
            end
            STOP_LOW:  if (tick) state_nxt = STOP_HIGH;
            STOP_HIGH: if (tick) state_nxt = STOP_END;
            STOP_END:  if (tick) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so the registered lines switch on the
    // same edge as the state itself.
    always_comb begin
        cur_byte = byte_nxt ? byte1 : byte0;
        sclk_nxt = 1'b1;
        din_nxt  = 1'b1;
        case (state_nxt)
            IDLE:      begin sclk_nxt = 1'b1; din_nxt = 1'b1;              end
            START:     begin sclk_nxt = 1'b1; din_nxt = 1'b0;              end
            BIT_LOW:   begin sclk_nxt = 1'b0; din_nxt = cur_byte[bit_nxt]; end
            BIT_HIGH:  begin sclk_nxt = 1'b1; din_nxt = cur_byte[bit_nxt]; end
            STOP_LOW:  begin sclk_nxt = 1'b0; din_nxt = 1'b0;              end
            STOP_HIGH: begin sclk_nxt = 1'b1; din_nxt = 1'b0;              end
            STOP_END:  begin sclk_nxt = 1'b1; din_nxt = 1'b1;              end
            default:   begin sclk_nxt = 1'b1; din_nxt = 1'b1;              end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_sclk <= 1'b1;
            o_din  <= 1'b1;
            busy   <= 1'b0;
        end else begin
            o_sclk <= sclk_nxt;
            o_din  <= din_nxt;
            busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_tm1640_serial_writer.sv
// Purpose: self-checking bench for tm1640_serial_writer with a line-level frame decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_tm1640_serial_writer;

    localparam int T = 4;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] pos   = 8'h00;
    logic [7:0] value = 8'h00;
    logic       o_sclk, o_din, busy;

    tm1640_serial_writer #(.TICK_CYCLES(T)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .valid  (valid),
        .pos    (pos),
        .value  (value),
        .o_sclk (o_sclk),
        .o_din  (o_din),
        .busy   (busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Line monitor: decodes start, bits on sclk rising, stop. The rising edge
    // into the stop sequence also looks like a bit and is dropped at stop.
    logic        mp_sclk = 1'b1, mp_din = 1'b1;
    bit          mon_in = 1'b0;
    int          mon_nbits = 0;
    logic [16:0] mon_data = '0;
    int          mon_starts = 0, mon_bad = 0, n_accepted = 0;
    int          fq_bits[$];
    logic [15:0] fq_data[$];

    always @(negedge CLK) begin
        if (RST) begin
            mon_in = 1'b0;
        end else if (mp_sclk && o_sclk && mp_din && !o_din) begin
            mon_starts++;
            if (mon_in || (mon_starts != n_accepted)) mon_bad++;
            mon_in    = 1'b1;
            mon_nbits = 0;
            mon_data  = '0;
        end else if (mon_in && !mp_sclk && o_sclk) begin
            if (mon_nbits < 17) mon_data[mon_nbits] = o_din;
            mon_nbits++;
        end else if (mon_in && mp_sclk && o_sclk && !mp_din && o_din) begin
            fq_bits.push_back(mon_nbits - 1);
            fq_data.push_back(mon_data[15:0]);
            mon_in = 1'b0;
        end
        mp_sclk = o_sclk;
        mp_din  = o_din;
    end

    // Reference model: frame content and busy length from the protocol rules.
    function automatic void model(input logic [7:0] p, input logic [7:0] v,
                                  output int nb, output logic [15:0] d, output int bc);
        int nbytes;
        nbytes = (p == 8'hFF) ? 1 : 2;
        nb = 8 * nbytes;
        d  = (nbytes == 1) ? {8'h00, v} : {v, p};
        bc = (1 + 16 * nbytes + 3) * T;
    endfunction

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy && guard < 1000) begin
            @(posedge CLK); #1;
            guard++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    // Called #1 after the accepting edge; counts clocks with busy high.
    task automatic count_busy(output int cnt);
        int guard;
        cnt = busy ? 1 : 0;
        guard = 0;
        while (busy && guard < 4000) begin
            @(posedge CLK); #1;
            guard++;
            if (!busy) break;
            cnt++;
        end
    endtask

    task automatic frame_check(input string tag, input int nb, input logic [15:0] d, input int exp_q);
        int          gb;
        logic [15:0] gd;
        check({tag, "_frames"}, fq_bits.size(), exp_q);
        if (fq_bits.size() > 0) begin
            gb = fq_bits.pop_front();
            gd = fq_data.pop_front();
            check({tag, "_nbits"}, gb, nb);
            check({tag, "_data"}, gd, d);
        end
    endtask

    task automatic do_xfer(input string tag, input logic [7:0] p, input logic [7:0] v,
                           input int nb, input logic [15:0] d, input int bc);
        int cnt;
        wait_idle(tag);
        @(negedge CLK);
        valid = 1'b1; pos = p; value = v;
        @(posedge CLK);
        n_accepted++;
        #1;
        check({tag, "_accept"}, busy, 1);
        // Scramble inputs after acceptance; they must not affect the frame.
        valid = 1'b0; pos = 8'($urandom); value = 8'($urandom);
        count_busy(cnt);
        check({tag, "_busy_clks"}, cnt, bc);
        frame_check(tag, nb, d, 1);
        check({tag, "_starts"}, mon_starts, n_accepted);
    endtask

    typedef struct {
        logic [7:0]  p;
        logic [7:0]  v;
        int          nbits;
        logic [15:0] data;
        int          busy_clks;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          nb, bc, cnt;
        logic [15:0] d;
        logic [7:0]  rp, rv;

        vecs[0] = '{8'hFF, 8'h89,  8, 16'h0089,  80};
        vecs[1] = '{8'hC3, 8'hE6, 16, 16'hE6C3, 144};
        vecs[2] = '{8'hFF, 8'h00,  8, 16'h0000,  80};
        vecs[3] = '{8'h00, 8'hFF, 16, 16'hFF00, 144};
        vecs[4] = '{8'hD0, 8'h55, 16, 16'h55D0, 144};
        vecs[5] = '{8'hFE, 8'h01, 16, 16'h01FE, 144};

        // Reset state, then idle with no valid.
        #12;
        check("rst_held", {o_sclk, o_din, busy}, 3'b110);
        @(negedge CLK); RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check("rst_idle", {o_sclk, o_din, busy}, 3'b110);
        end

        // Directed vector table.
        for (int i = 0; i < 6; i++)
            do_xfer($sformatf("vec%0d", i), vecs[i].p, vecs[i].v,
                    vecs[i].nbits, vecs[i].data, vecs[i].busy_clks);

        // Request while busy: held valid is ignored, then taken on the first idle edge.
        wait_idle("ib");
        @(negedge CLK);
        valid = 1'b1; pos = 8'hFF; value = 8'h89;
        @(posedge CLK); n_accepted++; #1;
        check("ib_accept_a", busy, 1);
        pos = 8'hC5; value = 8'h3C;
        count_busy(cnt);
        check("ib_busy_a", cnt, 80);
        @(posedge CLK); n_accepted++; #1;
        check("ib_accept_b", busy, 1);
        valid = 1'b0;
        count_busy(cnt);
        check("ib_busy_b", cnt, 144);
        frame_check("ib_a", 8, 16'h0089, 2);
        frame_check("ib_b", 16, 16'h3CC5, 1);

        // Reset during the first data bit.
        wait_idle("mr");
        @(negedge CLK);
        valid = 1'b1; pos = 8'hC3; value = 8'hE6;
        @(posedge CLK); n_accepted++; #1;
        valid = 1'b0;
        repeat (T) @(posedge CLK);
        #2;
        check("mr_in_bit", {o_sclk, busy}, 2'b01);
        RST = 1'b1;
        #1;
        check("mr_async", {o_sclk, o_din, busy}, 3'b110);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("mr_stay_idle", {o_sclk, o_din, busy}, 3'b110);
        check("mr_no_frame", fq_bits.size(), 0);
        do_xfer("mr_next", 8'hC7, 8'h5A, 16, 16'h5AC7, 144);

        // Full display sequence: display-on then all 16 digit addresses.
        model(8'h89 | 8'hFF, 8'h89, nb, d, bc);
        do_xfer("seq_cmd", 8'hFF, 8'h89, nb, d, bc);
        for (int a = 0; a < 16; a++) begin
            rp = 8'hC0 + 8'(a);
            rv = 8'($urandom);
            model(rp, rv, nb, d, bc);
            do_xfer($sformatf("seq_addr%0d", a), rp, rv, nb, d, bc);
        end

        // Randomized requests, a quarter of them command-only.
        for (int r = 0; r < 20; r++) begin
            rp = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            rv = 8'($urandom);
            model(rp, rv, nb, d, bc);
            do_xfer($sformatf("rnd%0d", r), rp, rv, nb, d, bc);
        end

        check("start_order", mon_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
